sd_block_responder: RTL and testbench

Responder (target) side of the hps_io sector-transfer handshake (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`).

- Serves 512-byte sectors as 256 16-bit words from a word-wide backing-memory port.
- Used in the core top as a bench/standalone stand-in for the HPS when exercising save-RAM load/save logic.
- Also used to mirror backup RAM into SDRAM/DDR3 without the HPS.

---
 rtl/sd_resp_pkg.sv | 19 +
 rtl/sd_block_responder.sv | 149 ++++++++++++++
 tb/tb_sd_block_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sd_block_responder sector-transfer target.
package sd_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdPut,
      StWrAddr,
      StWrLat,
      StWrReq,
      StDone,
      StGap
   } sd_resp_state_t;

   localparam int unsigned SECTOR_WORDS = 256;
   localparam logic [15:0] FILL_WORD    = 16'hFFFF;
   localparam int unsigned GAP_CYCLES   = 1;

endpackage

// File: rtl/sd_block_responder.sv
// Target side of the hps_io sector handshake: serves 256-word sectors from a word-wide memory port.
// Define SD_RESP_RANGE_EN to treat sectors with sd_lba bits above LBA_W set as out of range.
module sd_block_responder
   import sd_resp_pkg::*;
#(
   parameter int unsigned LBA_W  = 4,
   parameter int unsigned MEM_AW = LBA_W + 8
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [31:0]       sd_lba,
   input  logic              sd_rd,
   input  logic              sd_wr,
   output logic              sd_ack,
   output logic [7:0]        sd_buff_addr,
   output logic [15:0]       sd_buff_dout,
   output logic              sd_buff_wr,
   input  logic [15:0]       sd_buff_din,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [15:0]       mem_din,
   input  logic [15:0]       mem_q,
   input  logic              mem_ready,
   output logic              busy
);

   sd_resp_state_t   state_q, state_d;
   logic [7:0]       word_q, word_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic             ack_q, ack_d;
   logic             range_q, range_d;
   logic [15:0]      dout_q, dout_d;
   logic [15:0]      din_q, din_d;
   logic             req_in_range;
   logic             last_word;

`ifdef SD_RESP_RANGE_EN
   assign req_in_range = (sd_lba[31:LBA_W] == '0);
`else
   // Upper sector bits are dropped; the sector aliases modulo 2^LBA_W.
   logic unused_lba_hi;
   assign unused_lba_hi = ^sd_lba[31:LBA_W];
   assign req_in_range  = 1'b1;
`endif

   assign last_word = (word_q == 8'(SECTOR_WORDS - 1));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         word_q  <= '0;
         lba_q   <= '0;
         ack_q   <= 1'b0;
         range_q <= 1'b0;
         dout_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         lba_q   <= lba_d;
         ack_q   <= ack_d;
         range_q <= range_d;
         dout_q  <= dout_d;
         din_q   <= din_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      lba_d      = lba_q;
      ack_d      = ack_q;
      range_d    = range_q;
      dout_d     = dout_q;
      din_d      = din_q;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      sd_buff_wr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sd_rd || sd_wr) begin
               lba_d   = sd_lba[LBA_W-1:0];
               word_d  = '0;
               ack_d   = 1'b1;
               range_d = req_in_range;
               state_d = sd_rd ? StRdReq : StWrAddr;
            end
         end
         StRdReq: begin
            // Out-of-range sectors complete as if memory answered at once.
            mem_rd = range_q;
            if (mem_ready || !range_q) begin
               dout_d  = range_q ? mem_q : FILL_WORD;
               state_d = StRdPut;
            end
         end
         StRdPut: begin
            sd_buff_wr = 1'b1;
            if (last_word) begin
               state_d = StDone;
            end else begin
               word_d  = word_q + 8'd1;
               state_d = StRdReq;
            end
         end
         StWrAddr: state_d = StWrLat;
         StWrLat: begin
            // Buffer RAM is registered: data for word_q is valid one edge after the address.
            din_d   = sd_buff_din;
            state_d = StWrReq;
         end
         StWrReq: begin
            mem_wr = range_q;
            if (mem_ready || !range_q) begin
               if (last_word) begin
                  state_d = StDone;
               end else begin
                  word_d  = word_q + 8'd1;
                  state_d = StWrAddr;
               end
            end
         end
         StDone: begin
            ack_d   = 1'b0;
            word_d  = '0;
            state_d = StGap;
         end
         StGap: begin
            // word_q doubles as the gap counter once the sector is finished.
            if (word_q == 8'(GAP_CYCLES - 1)) begin
               word_d  = '0;
               state_d = StIdle;
            end else begin
               word_d = word_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign sd_ack       = ack_q;
   assign sd_buff_addr = word_q;
   assign sd_buff_dout = dout_q;
   assign mem_addr     = MEM_AW'({lba_q, word_q});
   assign mem_din      = din_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: table of sector transfers plus reset/back-to-back sequences.
module tb_sd_block_responder;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] sd_lba  = '0;
   logic        sd_rd   = 1'b0;
   logic        sd_wr   = 1'b0;
   logic        sd_ack;
   logic [7:0]  sd_buff_addr;
   logic [15:0] sd_buff_dout;
   logic        sd_buff_wr;
   logic [15:0] sd_buff_din = '0;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_din;
   logic [15:0] mem_q;
   logic        mem_ready;
   logic        busy;

   sd_block_responder dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_din      (mem_din),
      .mem_q        (mem_q),
      .mem_ready    (mem_ready),
      .busy         (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Backing memory with programmable ready latency; preload fills word a with a.
   logic [15:0] mem  [0:4095];
   logic [15:0] ibuf [0:255];
   logic [15:0] rbuf [0:255];
   int  cnt = 0, cur_delay = 0, delay_cfg = 0;
   bit  rand_mode = 1'b0;
   bit  preload_req = 1'b1;

   assign mem_ready = (mem_rd || mem_wr) && (cnt >= cur_delay);
   assign mem_q     = mem[mem_addr];

   always @(posedge clk_sys) begin
      if (preload_req) begin
         for (int a = 0; a < 4096; a++) mem[a] <= 16'(a);
      end else if (mem_ready) begin
         if (mem_wr) mem[mem_addr] <= mem_din;
         cnt       <= 0;
         cur_delay <= rand_mode ? int'($urandom_range(0, 7)) : delay_cfg;
      end else if (mem_rd || mem_wr) begin
         cnt <= cnt + 1;
      end else begin
         cnt       <= 0;
         cur_delay <= rand_mode ? int'($urandom_range(0, 7)) : delay_cfg;
      end
   end

   // Initiator buffer RAM side: registered read port, strobe capture with address-order tracking.
   int nstrobe = 0, seq_err = 0, exp_idx = 0;
   always @(posedge clk_sys) begin
      sd_buff_din <= ibuf[sd_buff_addr];
      if (!sd_ack) exp_idx <= 0;
      if (sd_buff_wr) begin
         rbuf[sd_buff_addr] <= sd_buff_dout;
         nstrobe <= nstrobe + 1;
         exp_idx <= exp_idx + 1;
         if (int'(sd_buff_addr) != exp_idx) seq_err <= seq_err + 1;
      end
   end

   // Protocol monitor: exclusive requests, request drop after ready, ack low gap >= 2.
   int mon_err = 0, req_cnt = 0, low_run = 0;
   bit prev_done = 1'b0, had_ack = 1'b0;
   always @(negedge clk_sys) begin
      if (mem_rd && mem_wr) mon_err <= mon_err + 1;
      else if (prev_done && (mem_rd || mem_wr)) mon_err <= mon_err + 1;
      else if (sd_ack && had_ack && low_run == 1) mon_err <= mon_err + 1;
      prev_done <= mem_ready;
      if (mem_rd || mem_wr) req_cnt <= req_cnt + 1;
      if (sd_ack) begin
         low_run <= 0;
         had_ack <= 1'b1;
      end else begin
         low_run <= low_run + 1;
      end
   end

   task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                          output int n, output int strobes, output int seqe, output int reqs);
      int s0, e0, r0, w;
      s0 = nstrobe; e0 = seq_err; r0 = req_cnt;
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      w = 0;
      do begin
         @(negedge clk_sys);
         w++;
      end while (!sd_ack && w < 20);
      check("ack_rise", sd_ack, 1);
      sd_rd = 1'b0; sd_wr = 1'b0;
      n = 0;
      while (sd_ack && n < 5000) begin
         n++;
         @(negedge clk_sys);
      end
      strobes = nstrobe - s0;
      seqe    = seq_err - e0;
      reqs    = req_cnt - r0;
   endtask

   task automatic check_data(input string name, input bit rd, input bit fill,
                             input logic [31:0] lba, input logic [15:0] base);
      int bad;
      logic [15:0] act, exp;
      logic [11:0] idx;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         idx = {lba[3:0], i[7:0]};
         act = rd ? rbuf[i] : mem[idx];
         exp = fill ? 16'hFFFF : base + 16'(i);
         if (act !== exp) bad++;
      end
      check(name, bad, 0);
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] lba;
      int          delay;
      int          exp_ack;
      int          exp_strobes;
      bit          fill;
      logic [15:0] base;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n, st, se, rq, w;
      vecs[0] = '{1'b1, 1'b0, 32'd3, 0,  513, 256, 1'b0, 16'h0300};
      vecs[1] = '{1'b0, 1'b1, 32'd5, 0,  769,   0, 1'b0, 16'hA500};
      vecs[2] = '{1'b1, 1'b0, 32'd5, 0,  513, 256, 1'b0, 16'hA500};
      vecs[3] = '{1'b1, 1'b0, 32'd7, 2, 1025, 256, 1'b0, 16'h0700};
      vecs[4] = '{1'b0, 1'b1, 32'd9, 1, 1025,   0, 1'b0, 16'hA500};
      vecs[5] = '{1'b1, 1'b1, 32'd2, 0,  513, 256, 1'b0, 16'h0200};
`ifdef SD_RESP_RANGE_EN
      vecs[6] = '{1'b1, 1'b0, 32'h10, 0, 513, 256, 1'b1, 16'h0000};
`else
      vecs[6] = '{1'b1, 1'b0, 32'h13, 0, 513, 256, 1'b0, 16'h0300};
`endif
      vecs[7] = '{1'b0, 1'b1, 32'd0, 3, 1537,   0, 1'b0, 16'hA500};
      for (int i = 0; i < 256; i++) ibuf[i] = 16'hA500 + 16'(i);

      #1;
      check("reset_state", {sd_ack, mem_rd, mem_wr, sd_buff_wr, busy, sd_buff_addr,
                            sd_buff_dout, mem_din, mem_addr}, 0);
      repeat (2) @(negedge clk_sys);
      preload_req = 1'b0;
      reset_n     = 1'b1;
      @(negedge clk_sys);

      for (int v = 0; v < 8; v++) begin
         delay_cfg = vecs[v].delay;
         @(negedge clk_sys);
         do_xfer(vecs[v].rd, vecs[v].wr, vecs[v].lba, n, st, se, rq);
         check($sformatf("v%0d_ack_len", v), n, vecs[v].exp_ack);
         check($sformatf("v%0d_strobes", v), st, vecs[v].exp_strobes);
         check($sformatf("v%0d_addr_seq", v), se, 0);
         check_data($sformatf("v%0d_data", v), vecs[v].rd, vecs[v].fill, vecs[v].lba,
                    vecs[v].base);
      end
      delay_cfg = 0;

      // Random ready latency 0..7 per request.
      rand_mode = 1'b1;
      @(negedge clk_sys);
      do_xfer(1'b1, 1'b0, 32'd11, n, st, se, rq);
      check("rand_rd_strobes", st, 256);
      check_data("rand_rd_data", 1'b1, 1'b0, 32'd11, 16'h0B00);
      do_xfer(1'b0, 1'b1, 32'd12, n, st, se, rq);
      check_data("rand_wr_data", 1'b0, 1'b0, 32'd12, 16'hA500);
      rand_mode = 1'b0;

      // Back-to-back: next request raised the cycle ack falls.
      @(negedge clk_sys);
      preload_req = 1'b1;
      @(negedge clk_sys);
      preload_req = 1'b0;
      @(negedge clk_sys);
      for (int s = 0; s < 16; s++) begin
         do_xfer(1'b1, 1'b0, 32'(s), n, st, se, rq);
         check_data($sformatf("b2b_s%0d_data", s), 1'b1, 1'b0, 32'(s), 16'(s << 8));
      end

      // Reset mid-transfer at word 100, then a fresh read.
      @(negedge clk_sys);
      sd_lba = 32'd4; sd_rd = 1'b1;
      w = 0;
      do begin
         @(negedge clk_sys);
         w++;
      end while (!sd_ack && w < 20);
      sd_rd = 1'b0;
      w = 0;
      while (!(sd_buff_wr && sd_buff_addr == 8'd100) && w < 1000) begin
         @(negedge clk_sys);
         w++;
      end
      check("reset_reach_word100", sd_buff_addr, 100);
      #2 reset_n = 1'b0;
      #1;
      check("reset_mid", {sd_ack, mem_rd, mem_wr, sd_buff_wr, busy, sd_buff_addr,
                          sd_buff_dout, mem_din, mem_addr}, 0);
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      do_xfer(1'b1, 1'b0, 32'd6, n, st, se, rq);
      check("post_reset_ack_len", n, 513);
      check("post_reset_strobes", st, 256);
      check("post_reset_addr_seq", se, 0);
      check_data("post_reset_data", 1'b1, 1'b0, 32'd6, 16'h0600);

`ifdef SD_RESP_RANGE_EN
      for (int i = 0; i < 256; i++) ibuf[i] = 16'h5A00 + 16'(i);
      @(negedge clk_sys);
      do_xfer(1'b0, 1'b1, 32'h10, n, st, se, rq);
      check("oor_wr_ack_len", n, 769);
      check("oor_wr_mem_reqs", rq, 0);
      check_data("oor_wr_mem_kept", 1'b0, 1'b0, 32'd0, 16'h0000);
      do_xfer(1'b1, 1'b0, 32'h10, n, st, se, rq);
      check("oor_rd_mem_reqs", rq, 0);
      check_data("oor_rd_fill", 1'b1, 1'b1, 32'h10, 16'h0000);
`endif

      repeat (2) @(negedge clk_sys);
      check("protocol", mon_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
